packet_sink_local: RTL and testbench
====================================

Name: packet_sink_local

Overview:
- Ejection-side consumer for a ring node. It is the counterpart of the local packet generator.
- Accepts valid packets from the router's local ejection link into a small FIFO.
- Drains the FIFO at a programmable rate and drives a registered backpressure flag back to the router.
- On each drain it checks the destination, computes latency against the global clock counter, and keeps receive, latency, misroute and drop statistics.

Parameters:
ROUTER_ID, 0, node ID; expected destination field of every ejected packet.
PACKET_SIZE, 49, packet width; [48] valid, [47:32] timestamp, [31:16] source, [15:0] destination.
BUFFER_SIZE, 4, FIFO depth; power of two, 2..64.
DRAIN_CYCLE, 1, minimum cycles between pops; 1 = pop every cycle; must be at least 1.
BUFFER_THRESHOLD, 1, backpressure asserts when free slots < BUFFER_THRESHOLD.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
clk_counter  input  16  global cycle counter used for latency
link_in  input  PACKET_SIZE  ejected packet; bit [PACKET_SIZE-1] = valid
backpressure_wr  output  1  registered stall request to the router
occupancy  output  $clog2(BUFFER_SIZE)+1  current FIFO entry count
total_packet_recieve  output  64  packets drained with correct destination
total_latency  output  64  sum of latencies of counted packets
max_latency  output  16  largest single latency observed
misroute_count  output  32  packets drained with destination != ROUTER_ID
drop_count  output  32  valid packets arriving while FIFO full with no pop
error_sticky  output  1  set on first misroute or drop; cleared only by reset

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FIFO pointers, occupancy and drain counter 0; FIFO contents zeroed. Reset mid-operation discards buffered packets; statistics restart from 0.
- Accept:
  - A packet is present when link_in[PACKET_SIZE-1]=1.
  - It is written at wr_ptr if occupancy < BUFFER_SIZE, or if occupancy == BUFFER_SIZE and a pop occurs in the same cycle.
  - Otherwise it is dropped: drop_count +1, error_sticky set.
  - An invalid link_in (MSB 0) is ignored.
- Pointers: wr_ptr and rd_ptr wrap modulo BUFFER_SIZE.
- Occupancy update: +1 on accept only; -1 on pop only; unchanged when accept and pop happen together.
- Drain pacing:
  - Drain counter pop_wait: a pop occurs when occupancy > 0 and pop_wait == 0.
  - On a pop, pop_wait loads DRAIN_CYCLE-1; otherwise it decrements while nonzero.
  - With DRAIN_CYCLE=1, the FIFO pops every cycle it is non-empty.
- Pop processing (same edge as pop; the head entry is read combinationally):
  - lat = clk_counter - head[47:32], 16-bit modulo subtraction, so counter wrap is handled.
  - If head[15:0] == ROUTER_ID: total_packet_recieve +1; total_latency += zero-extended lat; max_latency = max(max_latency, lat).
  - Otherwise: misroute_count +1 and error_sticky set; latency is not accumulated.
- Empty FIFO: no pop and no statistic change; pop_wait still counts down.
- Latency: a packet accepted at edge N is popped no earlier than edge N+1.
- Backpressure:
  - backpressure_wr at each edge = (BUFFER_SIZE - occupancy_next) < BUFFER_THRESHOLD, where occupancy_next is the value written at that edge.
  - It is therefore one cycle behind the router. The router may deliver one packet after assertion; that packet is accepted if a slot remains, otherwise it is counted as a drop.
- Counters: saturate at their maximum value (no wrap).
- The 64-bit adders must not truncate lat.

Test Plan:
1. Reset, then no traffic for 20 cycles -> all outputs 0, backpressure_wr=0.
2. ROUTER_ID=2, DRAIN_CYCLE=1: one packet {valid=1, ts=100, src=0, dst=2} when clk_counter=100 -> accepted, popped next edge with clk_counter=101; total_packet_recieve=1, total_latency=1, max_latency=1, occupancy back to 0.
3. Wrap: packet ts=0xFFFE popped at clk_counter=0x0003 -> lat=5; total_latency increases by 5, not a large value.
4. DRAIN_CYCLE=4, BUFFER_SIZE=4, BUFFER_THRESHOLD=1:
   - Valid packets on 6 consecutive cycles -> pops only every 4th cycle.
   - backpressure_wr rises on the edge occupancy reaches 4.
   - Extra arrivals while full with no pop give drop_count=1 and error_sticky=1.
   - When a full FIFO pops and accepts in the same cycle, there is no drop.
5. Packet dst=3 at ROUTER_ID=2 -> misroute_count=1, error_sticky=1, total_packet_recieve and total_latency unchanged.
6. Assert rst_n low mid-burst with occupancy=3 -> all outputs 0 immediately (async); after release, new packets are counted from 0.

Source files
------------

// File: rtl/packet_sink_local.sv
`default_nettype none
// ============================================================================
// Module   : packet_sink_local
// Brief    : Ring-node ejection sink. Buffers ejected packets, drains them at
//            a programmable rate and keeps latency/misroute/drop statistics.
// Revision : 1.0 - initial release
// ============================================================================
module packet_sink_local #(
    parameter int ROUTER_ID        = 0,
    parameter int PACKET_SIZE      = 49,
    parameter int BUFFER_SIZE      = 4,
    parameter int DRAIN_CYCLE      = 1,
    parameter int BUFFER_THRESHOLD = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [15:0]                   clk_counter,
    input  logic [PACKET_SIZE-1:0]        link_in,
    output logic                          backpressure_wr,
    output logic [$clog2(BUFFER_SIZE):0]  occupancy,
    output logic [63:0]                   total_packet_recieve,
    output logic [63:0]                   total_latency,
    output logic [15:0]                   max_latency,
    output logic [31:0]                   misroute_count,
    output logic [31:0]                   drop_count,
    output logic                          error_sticky
);

    localparam int c_PTR_W  = $clog2(BUFFER_SIZE);
    localparam int c_OCC_W  = c_PTR_W + 1;
    localparam int c_WAIT_W = (DRAIN_CYCLE > 1) ? $clog2(DRAIN_CYCLE) : 1;

    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(DRAIN_CYCLE - 1);
    localparam logic [c_OCC_W-1:0]  c_DEPTH     = c_OCC_W'(BUFFER_SIZE);
    localparam logic [15:0]         c_DEST      = 16'(ROUTER_ID);

    logic [PACKET_SIZE-1:0] r_mem [BUFFER_SIZE];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_OCC_W-1:0]     r_occupancy;
    logic [c_WAIT_W-1:0]    r_pop_wait;
    logic                   r_backpressure;
    logic [63:0]            r_rx_count;
    logic [63:0]            r_lat_sum;
    logic [15:0]            r_lat_max;
    logic [31:0]            r_misroute;
    logic [31:0]            r_drop;
    logic                   r_error;

    logic                   w_in_valid;
    logic                   w_pop;
    logic                   w_accept;
    logic                   w_drop;
    logic [PACKET_SIZE-1:0] w_head;
    logic [15:0]            w_lat;
    logic                   w_dst_ok;
    logic [64:0]            w_lat_sum;
    logic [c_OCC_W-1:0]     w_occ_next;
    logic [c_OCC_W-1:0]     w_free_next;
    logic                   w_bp_next;

    assign w_in_valid = link_in[PACKET_SIZE-1];
    assign w_pop      = (r_occupancy != '0) && (r_pop_wait == '0);
    // A full buffer still accepts when the head leaves on the same edge.
    assign w_accept   = w_in_valid && ((r_occupancy < c_DEPTH) || w_pop);
    assign w_drop     = w_in_valid && !w_accept;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_lat      = clk_counter - w_head[47:32];
    assign w_dst_ok   = (w_head[15:0] == c_DEST);
    assign w_lat_sum  = {1'b0, r_lat_sum} + {49'd0, w_lat};

    always_comb begin
        w_occ_next = r_occupancy;
        if (w_accept && !w_pop) begin
            w_occ_next = r_occupancy + 1'b1;
        end else if (w_pop && !w_accept) begin
            w_occ_next = r_occupancy - 1'b1;
        end
    end

    assign w_free_next = c_DEPTH - w_occ_next;
    assign w_bp_next   = 32'(w_free_next) < 32'(BUFFER_THRESHOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept) begin
            r_mem[r_wr_ptr] <= link_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_occupancy    <= '0;
            r_pop_wait     <= '0;
            r_backpressure <= 1'b0;
        end else begin
            r_occupancy    <= w_occ_next;
            r_backpressure <= w_bp_next;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_pop_wait <= c_WAIT_LOAD;
            end else if (r_pop_wait != '0) begin
                r_pop_wait <= r_pop_wait - 1'b1;
            end
        end
    end

    // Statistics counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_count <= '0;
            r_lat_sum  <= '0;
            r_lat_max  <= '0;
            r_misroute <= '0;
            r_drop     <= '0;
            r_error    <= 1'b0;
        end else begin
            if (w_pop) begin
                if (w_dst_ok) begin
                    if (r_rx_count != '1) begin
                        r_rx_count <= r_rx_count + 64'd1;
                    end
                    r_lat_sum <= w_lat_sum[64] ? '1 : w_lat_sum[63:0];
                    if (w_lat > r_lat_max) begin
                        r_lat_max <= w_lat;
                    end
                end else begin
                    if (r_misroute != '1) begin
                        r_misroute <= r_misroute + 32'd1;
                    end
                    r_error <= 1'b1;
                end
            end
            if (w_drop) begin
                if (r_drop != '1) begin
                    r_drop <= r_drop + 32'd1;
                end
                r_error <= 1'b1;
            end
        end
    end

    assign backpressure_wr      = r_backpressure;
    assign occupancy            = r_occupancy;
    assign total_packet_recieve = r_rx_count;
    assign total_latency        = r_lat_sum;
    assign max_latency          = r_lat_max;
    assign misroute_count       = r_misroute;
    assign drop_count           = r_drop;
    assign error_sticky         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_packet_sink_local.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_sink_local
// Brief    : Self-checking bench for packet_sink_local against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_sink_local;

    localparam int RID = 2;
    localparam int BS  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] clk_counter = '0;
    logic [48:0] link_in = '0;

    always #5 clk = ~clk;

    // instance a: pops every cycle; instance b: pops every 4th cycle
    logic        bp_a, bp_b, err_a, err_b;
    logic [2:0]  occ_a, occ_b;
    logic [63:0] rx_a, rx_b, tl_a, tl_b;
    logic [15:0] mx_a, mx_b;
    logic [31:0] mis_a, mis_b, drp_a, drp_b;

    packet_sink_local #(.ROUTER_ID(RID), .PACKET_SIZE(49), .BUFFER_SIZE(BS),
                        .DRAIN_CYCLE(1), .BUFFER_THRESHOLD(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter), .link_in(link_in),
        .backpressure_wr(bp_a), .occupancy(occ_a), .total_packet_recieve(rx_a),
        .total_latency(tl_a), .max_latency(mx_a), .misroute_count(mis_a),
        .drop_count(drp_a), .error_sticky(err_a)
    );

    packet_sink_local #(.ROUTER_ID(RID), .PACKET_SIZE(49), .BUFFER_SIZE(BS),
                        .DRAIN_CYCLE(4), .BUFFER_THRESHOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter), .link_in(link_in),
        .backpressure_wr(bp_b), .occupancy(occ_b), .total_packet_recieve(rx_b),
        .total_latency(tl_b), .max_latency(mx_b), .misroute_count(mis_b),
        .drop_count(drp_b), .error_sticky(err_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one packet queue per instance plus pop-spacing by cycle index.
    int          drain [2] = '{1, 4};
    int          thr   [2] = '{2, 1};
    logic [48:0] q0[$];
    logic [48:0] q1[$];
    logic [63:0] m_rx [2], m_tl [2];
    logic [15:0] m_max [2];
    logic [31:0] m_mis [2], m_drop [2];
    logic        m_err [2], m_bp [2];
    int          m_last [2];
    int          cyc = 0;
    logic [15:0] cc = '0;

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpop(input int k, output logic [48:0] p);
        if (k == 0) p = q0.pop_front();
        else        p = q1.pop_front();
    endtask

    task automatic qpush(input int k, input logic [48:0] p);
        if (k == 0) q0.push_back(p);
        else        q1.push_back(p);
    endtask

    task automatic mreset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_rx[k] = '0; m_tl[k] = '0; m_max[k] = '0; m_mis[k] = '0;
            m_drop[k] = '0; m_err[k] = 1'b0; m_bp[k] = 1'b0; m_last[k] = -1000;
        end
    endtask

    task automatic model_step(input logic [48:0] pkt, input logic [15:0] now);
        for (int k = 0; k < 2; k++) begin
            logic [48:0] h;
            logic [15:0] lat;
            if (qsize(k) > 0 && (cyc - m_last[k]) >= drain[k]) begin
                qpop(k, h);
                m_last[k] = cyc;
                lat = now - h[47:32];
                if (h[15:0] == 16'(RID)) begin
                    m_rx[k] = m_rx[k] + 1;
                    m_tl[k] = m_tl[k] + 64'(lat);
                    if (lat > m_max[k]) m_max[k] = lat;
                end else begin
                    m_mis[k] = m_mis[k] + 1;
                    m_err[k] = 1'b1;
                end
            end
            if (pkt[48]) begin
                if (qsize(k) < BS) qpush(k, pkt);
                else begin
                    m_drop[k] = m_drop[k] + 1;
                    m_err[k]  = 1'b1;
                end
            end
            m_bp[k] = (BS - qsize(k)) < thr[k];
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("a_bp",  64'(bp_a),  64'(m_bp[0]));
        chk("a_occ", 64'(occ_a), 64'(qsize(0)));
        chk("a_rx",  rx_a,       m_rx[0]);
        chk("a_lat", tl_a,       m_tl[0]);
        chk("a_max", 64'(mx_a),  64'(m_max[0]));
        chk("a_mis", 64'(mis_a), 64'(m_mis[0]));
        chk("a_drp", 64'(drp_a), 64'(m_drop[0]));
        chk("a_err", 64'(err_a), 64'(m_err[0]));
        chk("b_bp",  64'(bp_b),  64'(m_bp[1]));
        chk("b_occ", 64'(occ_b), 64'(qsize(1)));
        chk("b_rx",  rx_b,       m_rx[1]);
        chk("b_lat", tl_b,       m_tl[1]);
        chk("b_max", 64'(mx_b),  64'(m_max[1]));
        chk("b_mis", 64'(mis_b), 64'(m_mis[1]));
        chk("b_drp", 64'(drp_b), 64'(m_drop[1]));
        chk("b_err", 64'(err_b), 64'(m_err[1]));
    endtask

    // Called just after an edge: drive inputs, step model, wait for the edge, compare.
    task automatic cycle(input bit v, input logic [15:0] ts, input logic [15:0] dst);
        link_in     = {v, ts, 16'($urandom), dst};
        clk_counter = cc;
        model_step(link_in, cc);
        @(posedge clk);
        #1;
        check_all();
        cc = cc + 16'd1;
    endtask

    task automatic rand_phase(input int n, input int pct_valid);
        for (int i = 0; i < n; i++) begin
            bit          v;
            logic [15:0] dst;
            v   = ($urandom_range(99) < pct_valid);
            dst = ($urandom_range(9) < 8) ? 16'(RID) : 16'($urandom_range(7));
            cycle(v, cc - 16'($urandom_range(300)), dst);
        end
    endtask

    logic [63:0] tl_before;
    logic [31:0] mis_before;

    initial begin
        mreset();
        #12;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) cycle(1'b0, 16'd0, 16'd0);

        cc = 16'd100;
        cycle(1'b1, 16'd100, 16'(RID));
        cycle(1'b0, 16'd0, 16'd0);
        chk("single_rx",  rx_a, 64'd1);
        chk("single_lat", tl_a, 64'd1);
        chk("single_max", 64'(mx_a), 64'd1);
        chk("single_occ", 64'(occ_a), 64'd0);

        for (int i = 0; i < 6; i++) cycle(1'b0, 16'd0, 16'd0);
        cc = 16'd2;
        tl_before = tl_a;
        cycle(1'b1, 16'hFFFE, 16'(RID));
        cycle(1'b0, 16'd0, 16'd0);
        chk("wrap_lat", tl_a - tl_before, 64'd5);

        // Burst fills instance b: drop while full, accept-with-pop when full.
        for (int i = 0; i < 8; i++) cycle(1'b1, cc - 16'd3, 16'(RID));
        chk("burst_drop_seen", 64'(drp_b != 0), 64'd1);
        chk("burst_err",       64'(err_b), 64'd1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 16'd0, 16'd0);

        mis_before = mis_a;
        tl_before  = tl_a;
        cycle(1'b1, cc, 16'd3);
        cycle(1'b0, 16'd0, 16'd0);
        chk("misroute_inc", 64'(mis_a - mis_before), 64'd1);
        chk("misroute_lat", tl_a, tl_before);

        cc = 16'hFF00;
        rand_phase(500, 25);
        rand_phase(500, 60);
        rand_phase(500, 95);
        for (int i = 0; i < 20; i++) cycle(1'b0, 16'd0, 16'd0);

        for (int i = 0; i < 4; i++) cycle(1'b1, cc - 16'd7, 16'(RID));
        chk("pre_reset_occ", 64'(occ_b), 64'd3);
        rst_n   = 1'b0;
        link_in = '0;
        #1;
        mreset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rand_phase(200, 70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
